// File: rtl/pc_sel_pkg.sv
// Shared constants for the PC select/register block.
package pc_sel_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0180;
  localparam int unsigned DEF_STEP     = 4;
  localparam int unsigned MAX_NSRC     = 8;

  // Index width for an n-input encoder; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_prio_enc.sv
// Highest-index-wins priority encoder over the redirect request vector.
module pc_prio_enc
  import pc_sel_pkg::*;
#(
  parameter int unsigned NSRC  = 4,
  parameter int unsigned IDX_W = idx_width(NSRC)
) (
  input  logic [NSRC-1:0]  req,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  // Later (higher) indices overwrite earlier ones, so the top set bit wins.
  always_comb begin
    idx_c = '0;
    any_c = |req;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (req[i]) idx_c = IDX_W'(i);
    end
  end

endmodule

// File: rtl/pc_sel_reg.sv
// PC register with prioritised redirects, stall hold and a pending redirect slot.
// Optional alignment check on redirect targets: define PC_SEL_ALIGN_CHECK_EN.
module pc_sel_reg
  import pc_sel_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      NSRC     = 4,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
  parameter int unsigned      STEP     = DEF_STEP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic [NSRC-1:0]       src_req,
  input  logic [NSRC*WIDTH-1:0] src_pc,
  output logic [WIDTH-1:0]      pc,
  output logic                  pc_valid,
  output logic                  redir,
  output logic                  pend,
  output logic                  misalign
);

  localparam int unsigned IDX_W = idx_width(NSRC);

  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic [WIDTH-1:0] win_pc;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] pend_pc;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] pend_pc_nxt;
  logic             pend_nxt;
  logic             redir_nxt;

`ifdef PC_SEL_ALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
  logic mis_nxt;
`endif

  pc_prio_enc #(
    .NSRC  (NSRC),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req   (src_req),
    .idx_c (win_idx),
    .any_c (win_any)
  );

  // Target mux: pick the winning source's slice of the flattened target bus.
  always_comb begin
    win_pc = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (IDX_W'(i) == win_idx) win_pc = src_pc[i*WIDTH +: WIDTH];
    end
  end

  // Next PC / pending state; nothing advances until the cycle after reset release.
  always_comb begin
    pc_nxt      = pc;
    pend_nxt    = pend;
    pend_pc_nxt = pend_pc;
    redir_nxt   = 1'b0;
    tgt         = win_any ? win_pc : pend_pc;
`ifdef PC_SEL_ALIGN_CHECK_EN
    mis_nxt     = 1'b0;
`endif
    if (pc_valid) begin
      if (stall) begin
        if (win_any) begin
          pend_nxt    = 1'b1;
          pend_pc_nxt = win_pc;
        end
      end else begin
        pend_nxt = 1'b0;
        if (win_any || pend) begin
          redir_nxt = 1'b1;
          pc_nxt    = tgt;
`ifdef PC_SEL_ALIGN_CHECK_EN
          if (|(tgt & ALIGN_MASK)) begin
            pc_nxt  = WIDTH'(EXC_VECTOR);
            mis_nxt = 1'b1;
          end
`endif
        end else begin
          pc_nxt = pc + WIDTH'(STEP);
        end
      end
    end
  end

  // PC, status and pending-target registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      pc_valid <= 1'b0;
      redir    <= 1'b0;
      pend     <= 1'b0;
      pend_pc  <= '0;
    end else begin
      pc       <= pc_nxt;
      pc_valid <= 1'b1;
      redir    <= redir_nxt;
      pend     <= pend_nxt;
      pend_pc  <= pend_pc_nxt;
    end
  end

`ifdef PC_SEL_ALIGN_CHECK_EN
  // One-cycle misalignment pulse accompanying the exception-vector load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= mis_nxt;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sel_reg.sv
// Randomised + directed bench for pc_sel_reg against a cycle-level reference model.
module tb_pc_sel_reg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NSRC  = 4;
  localparam int unsigned STEP  = 4;
  localparam logic [31:0] RPC   = 32'hBFC0_0000;
  localparam logic [31:0] EXC   = 32'hBFC0_0180;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  stall;
  logic [NSRC-1:0]       src_req;
  logic [NSRC*WIDTH-1:0] src_pc;
  logic [WIDTH-1:0]      pc;
  logic                  pc_valid;
  logic                  redir;
  logic                  pend;
  logic                  misalign;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_valid, m_redir, m_pend, m_mis;

  pc_sel_reg #(
    .WIDTH    (WIDTH),
    .NSRC     (NSRC),
    .RESET_PC (RPC),
    .STEP     (STEP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .src_req  (src_req),
    .src_pc   (src_pc),
    .pc       (pc),
    .pc_valid (pc_valid),
    .redir    (redir),
    .pend     (pend),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},       64'(pc),       64'(m_pc));
    check({tag, ".pc_valid"}, 64'(pc_valid), 64'(m_valid));
    check({tag, ".redir"},    64'(redir),    64'(m_redir));
    check({tag, ".pend"},     64'(pend),     64'(m_pend));
    check({tag, ".misalign"}, 64'(misalign), 64'(m_mis));
  endtask

  task automatic model_reset();
    m_pc = RPC; m_tgt = '0; m_valid = 0; m_redir = 0; m_pend = 0; m_mis = 0;
  endtask

  function automatic logic [31:0] tgt_of(input int i);
    return src_pc[i*WIDTH +: WIDTH];
  endfunction

  // Apply the spec rules for one rising edge to the model.
  task automatic model_edge();
    int          win;
    logic [31:0] t;
    bit          have;
    win = -1;
    for (int i = 0; i < int'(NSRC); i++) if (src_req[i]) win = i;
    m_redir = 0;
    m_mis   = 0;
    if (!m_valid) begin
      m_valid = 1;
    end else if (stall) begin
      if (win >= 0) begin m_pend = 1; m_tgt = tgt_of(win); end
    end else begin
      have = 1;
      t    = m_pc;
      if (win >= 0)    t = tgt_of(win);
      else if (m_pend) t = m_tgt;
      else             have = 0;
      m_pend = 0;
      if (have) begin
        m_redir = 1;
`ifdef PC_SEL_ALIGN_CHECK_EN
        if ((t % STEP) != 0) begin t = EXC; m_mis = 1; end
`endif
        m_pc = t;
      end else begin
        m_pc = m_pc + STEP;
      end
    end
  endtask

  task automatic set_src(input int i, input logic [31:0] v);
    src_pc[i*WIDTH +: WIDTH] = v;
  endtask

  // Fill every slot with junk so non-requesting targets are exercised as don't-care.
  task automatic junk_src();
    for (int i = 0; i < int'(NSRC); i++) set_src(i, $urandom);
  endtask

  task automatic cycle(input string tag, input bit st, input logic [NSRC-1:0] rq);
    stall   = st;
    src_req = rq;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1; stall = 1'b0; src_req = '0; src_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");

    // Reset release: pc holds one cycle with pc_valid, then counts
    @(negedge clk); rst = 1'b0;
    #1;
    cycle("rel0", 0, 4'b0000);
    check("rel0.pc_abs", 64'(pc), 64'(32'hBFC0_0000));
    cycle("rel1", 0, 4'b0000);
    check("rel1.pc_abs", 64'(pc), 64'(32'hBFC0_0004));
    cycle("rel2", 0, 4'b0000);
    check("rel2.pc_abs", 64'(pc), 64'(32'hBFC0_0008));

    // Highest index wins, one-cycle redir pulse
    junk_src(); set_src(0, 32'h0000_1000); set_src(2, 32'h0000_2000);
    cycle("prio", 0, 4'b0101);
    check("prio.pc_abs", 64'(pc), 64'(32'h0000_2000));
    junk_src();
    cycle("prio_after", 0, 4'b0000);

    // Stall with overwriting pending captures, then release
    junk_src(); set_src(1, 32'h0000_3000);
    cycle("stall1", 1, 4'b0010);
    junk_src(); set_src(0, 32'h0000_4000);
    cycle("stall2", 1, 4'b0001);
    junk_src();
    cycle("stall3", 1, 4'b0000);
    cycle("stall_rel", 0, 4'b0000);
    check("stall_rel.pc_abs", 64'(pc), 64'(32'h0000_4000));

    // Live request beats pending target on release
    junk_src(); set_src(0, 32'h0000_4000);
    cycle("pend_cap", 1, 4'b0001);
    junk_src(); set_src(3, 32'h0000_5000);
    cycle("live_win", 0, 4'b1000);
    check("live_win.pc_abs", 64'(pc), 64'(32'h0000_5000));
    junk_src();
    cycle("live_after", 0, 4'b0000);

    // Wrap at top of address space
    junk_src(); set_src(1, 32'hFFFF_FFFC);
    cycle("to_top", 0, 4'b0010);
    cycle("wrap", 0, 4'b0000);
    check("wrap.pc_abs", 64'(pc), 64'(32'h0000_0000));

    // Misaligned target (behaviour depends on build option; model follows it)
    junk_src(); set_src(2, 32'h0000_2002);
    cycle("misal", 0, 4'b0100);
    cycle("misal_after", 0, 4'b0000);

    // Reset mid-stall discards the pending redirect
    junk_src(); set_src(3, 32'h0000_7000);
    cycle("pre_rst", 1, 4'b1000);
    @(negedge clk); rst = 1'b1; src_req = '0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk); rst = 1'b0;
    #1;
    cycle("post_rst0", 0, 4'b0000);
    cycle("post_rst1", 0, 4'b0000);
    check("post_rst1.pc_abs", 64'(pc), 64'(32'hBFC0_0004));

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      logic [NSRC-1:0] rq;
      bit              st;
      junk_src();
      for (int i = 0; i < int'(NSRC); i++) begin
        v = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) v[1] = 1'b1;
        set_src(i, v);
      end
      st = ($urandom_range(0, 9) < 3);
      rq = ($urandom_range(0, 9) < 4) ? NSRC'($urandom) : '0;
      cycle("rand", st, rq);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
